// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory access width codes and legality helper shared by RAM, LSU and arbiter
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_D  = 3'd3,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5,
        MEM_WU = 3'd6
    } mem_wid_e;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_LS = 1;

    // Stores only know signed-agnostic widths B..D; loads may also zero-extend.
    function automatic logic mem_wid_legal(input logic is_store, input logic [2:0] wid);
        if (is_store) begin
            return wid <= 3'd3;
        end
        return wid <= 3'd6;
    endfunction

endpackage

// File: rtl/ram_arb_prio.sv
// rtl/ram_arb_prio.sv - combinational IF/LS winner select with starvation override
module ram_arb_prio
    import mem_pkg::*;
(
    input  logic       if_req_i,
    input  logic       ls_req_i,
    input  logic       if_starved_i,
    output logic [1:0] gnt_o
);

    // LS wins by default; IF wins when alone or once it has waited long enough.
    always_comb begin
        gnt_o = '0;
        if (if_req_i && (if_starved_i || !ls_req_i)) begin
            gnt_o[GNT_IF] = 1'b1;
        end else if (ls_req_i) begin
            gnt_o[GNT_LS] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port data RAM arbiter between instruction fetch and load/store
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned RAM_SIZE     = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [RAM_SIZE-1:0]   if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [RAM_SIZE-1:0]   ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    input  logic [2:0]            ls_wid_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  ls_err_o,
    output logic [RAM_SIZE-1:0]   ram_raddr_o,
    output logic [RAM_SIZE-1:0]   ram_waddr_o,
    output logic                  ram_read_o,
    output logic                  ram_write_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic [2:0]            ram_wid_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  ls_rvalid_q, ls_rvalid_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                  ls_err_q, ls_err_d;

    logic [1:0] gnt;
    logic       if_gnt;
    logic       ls_gnt;
    logic       ls_legal;

    ram_arb_prio u_prio (
        .if_req_i     (if_req_i),
        .ls_req_i     (ls_req_i),
        .if_starved_i (starve_cnt_q == CNT_MAX),
        .gnt_o        (gnt)
    );

    // Reset is folded into the grants so nothing reaches the RAM while it is held.
    assign if_gnt   = gnt[GNT_IF] & ~rst;
    assign ls_gnt   = gnt[GNT_LS] & ~rst;
    assign ls_legal = mem_wid_legal(ls_we_i, ls_wid_i);

    assign if_gnt_o    = if_gnt;
    assign ls_gnt_o    = ls_gnt;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_err_o    = ls_err_q;

    // RAM port mux; the unused address is driven to the complement so the RAM never forwards.
    always_comb begin
        ram_read_o  = 1'b0;
        ram_write_o = 1'b0;
        ram_raddr_o = '0;
        ram_waddr_o = '0;
        ram_data_o  = '0;
        ram_wid_o   = '0;
        if (if_gnt) begin
            ram_read_o  = 1'b1;
            ram_raddr_o = if_addr_i;
            ram_waddr_o = ~if_addr_i;
            ram_wid_o   = MEM_D;
        end else if (ls_gnt && ls_legal) begin
            ram_wid_o = ls_wid_i;
            if (ls_we_i) begin
                ram_write_o = 1'b1;
                ram_waddr_o = ls_addr_i;
                ram_raddr_o = ~ls_addr_i;
                ram_data_o  = ls_wdata_i;
            end else begin
                ram_read_o  = 1'b1;
                ram_raddr_o = ls_addr_i;
                ram_waddr_o = ~ls_addr_i;
            end
        end
    end

    // Next-state for the starvation counter and the response registers.
    always_comb begin
        starve_cnt_d = '0;
        if (if_req_i && !if_gnt) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
        end

        if_rvalid_d = if_gnt;
        if_rdata_d  = if_gnt ? ram_data_i : if_rdata_q;

        ls_rvalid_d = ls_gnt;
        ls_err_d    = ls_gnt & ~ls_legal;
        ls_rdata_d  = ls_rdata_q;
        if (ls_gnt) begin
            ls_rdata_d = (ls_legal && !ls_we_i) ? ram_data_i : '0;
        end
    end

    // State registers; asynchronous reset drops any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ls_rvalid_q  <= 1'b0;
            ls_rdata_q   <= '0;
            ls_err_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rvalid_q  <= ls_rvalid_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_err_q     <= ls_err_d;
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-ported data RAM between the instruction-fetch requester (IF) and the load/store requester (LS). Grants at most one access per cycle and drives the RAM's read/write ports. Registers read data into a one-cycle response pulse per port. Prevents IF starvation with a bounded-wait counter, and suppresses the RAM's read-write address forwarding on pure reads.

## Interface
Parameters:
- DATA_WIDTH, 64, data word width
- RAM_SIZE, 16, word-address width
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF gets priority (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req_i  in  1  IF read request, held until granted
- if_addr_i  in  RAM_SIZE  IF word address
- if_gnt_o  out  1  IF granted this cycle
- if_rvalid_o  out  1  IF read data valid (one-cycle pulse)
- if_rdata_o  out  DATA_WIDTH  IF read data
- ls_req_i  in  1  LS request, held until granted
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  RAM_SIZE  LS word address
- ls_wdata_i  in  DATA_WIDTH  store data
- ls_wid_i  in  3  access width/sign code (B/H/W/D/BU/HU/WU = 0..6)
- ls_gnt_o  out  1  LS granted this cycle
- ls_rvalid_o  out  1  LS response (load data or store ack), one-cycle pulse
- ls_rdata_o  out  DATA_WIDTH  load data; 0 for store ack
- ls_err_o  out  1  pulses with ls_rvalid_o on illegal code
- ram_raddr_o, ram_waddr_o  out  RAM_SIZE  RAM addresses
- ram_read_o, ram_write_o  out  1  RAM strobes
- ram_data_o  out  DATA_WIDTH  RAM write data
- ram_wid_o  out  3  RAM width code
- ram_data_i  in  DATA_WIDTH  RAM combinational read data

## Operation
- Arbitration is combinational each cycle:
  - LS wins by default.
  - IF wins if `starve_cnt == STARVE_LIMIT` and `if_req_i` is high.
  - A lone requester always wins.
- `starve_cnt` behaviour:
  - Increments, saturating at STARVE_LIMIT, when `if_req_i` is high and IF is denied.
  - Clears when IF is granted or `if_req_i` is low.
- IF grant drives:
  - `ram_read_o = 1`, `ram_raddr_o = if_addr_i`, `ram_wid_o = 3'b011` (D).
  - `ram_waddr_o = ~if_addr_i`, which defeats RAM forwarding.
  - `ram_write_o = 0`, `ram_data_o = 0`.
- LS load grant:
  - Same as IF grant, but with `ls_addr_i` and `ram_wid_o = ls_wid_i`.
  - Codes 4–6 are legal for loads; code 7 is illegal.
- LS store grant:
  - `ram_write_o = 1`, `ram_waddr_o = ls_addr_i`, `ram_data_o = ls_wdata_i`, `ram_wid_o = ls_wid_i`.
  - `ram_read_o = 0`, `ram_raddr_o = ~ls_addr_i`.
  - Legal store codes are 0–3; codes 4–7 are illegal.
- Illegal code:
  - The request is still granted and consumed.
  - RAM strobes are both 0.
  - Response is `ls_rvalid_o = 1`, `ls_err_o = 1`, `ls_rdata_o = 0`.
- No grant: all ram_* outputs are 0.
- Response registers:
  - On posedge after a granted read, `*_rdata_o <= ram_data_i` and `*_rvalid_o <= 1` for the winner.
  - All `rvalid` outputs return to 0 the following cycle unless a new grant occurs.

## Timing
- Grant and RAM drive occur in the same cycle the request is seen (0-cycle decision).
- Read latency is 1 cycle: grant in cycle N, `rvalid`/`rdata` in cycle N+1.
- Store ack: `ls_rvalid_o` in N+1. RAM is updated at the posedge ending cycle N.
- Store at N followed by load of the same address at N+1 returns the new data.
- Back-to-back grants are allowed every cycle; no bubbles.
- Reset values: all registered outputs 0, `starve_cnt = 0`.
- While `rst` is high:
  - Both grants are forced to 0.
  - `ram_read_o = ram_write_o = 0`.
- Reset mid-operation: a response pending for the next cycle is dropped, with no `rvalid` after reset release.
- STARVE_LIMIT boundary: with LS requesting continuously and IF requesting from cycle 0, IF is granted in cycle STARVE_LIMIT.

## Structure
- Shared package `mem_pkg`:
  - Width codes MEM_B..MEM_WU plus a legality function for load/store.
  - The package is shared with the RAM and the LSU decoder.
- One sub-module, `ram_arb_prio`:
  - Combinational winner select from the two request lines and `starve_cnt`.
  - Outputs a one-hot grant vector.
- Top level holds the counter, the RAM port mux and the response registers.

## Test plan
- Single IF read of address 0x0010 holding 0xDEAD_BEEF_0000_0001:
  - `if_gnt_o = 1` in cycle N.
  - `if_rvalid_o = 1` with that data in N+1, and 0 in N+2.
- LS store MEM_B of 0xFF to address 0x0020 (word previously 0x1122334455667788), then load MEM_D next cycle:
  - Returns 0x11223344556677FF.
  - Load MEM_B of the same address returns 0xFFFF_FFFF_FFFF_FFFF.
- Both requesting continuously with STARVE_LIMIT = 4:
  - LS granted in cycles 0–3, IF in cycle 4, LS in cycles 5–8, IF in cycle 9.
- LS store with wid 4 (BU):
  - `ls_gnt_o = 1`, `ram_write_o = 0`.
  - Next cycle: `ls_rvalid_o = 1`, `ls_err_o = 1`, RAM word unchanged.
- IF read of address A while the RAM write-data bus holds arbitrary data:
  - `ram_waddr_o = ~A`, and the returned data is the stored word, not forwarded data.
- `rst` asserted asynchronously in the cycle after an IF grant:
  - `if_rvalid_o` drops immediately and no response appears after release.
  - `starve_cnt` reads 0.
